// File: rtl/fb_writer.sv
// Byte-stream packet parser that writes pixels into the scrambled frame-buffer layout
// and acknowledges each packet with 'K' (done) or 'E' (error / timeout).
module fb_writer #(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [19:0] TIMEOUT    = 20'd48000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic [7:0]            tx_data,
    output logic                  tx_strobe,
    output logic                  frame_done,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, CMD, FRAME, PX_X, PX_Y, PX_V} state_t;

    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h45;

    state_t                state, state_next;
    logic [7:0]            x, x_next, y, y_next;
    logic [19:0]           idle_count, idle_count_next;
    logic                  wr_enable_next, tx_strobe_next, frame_done_next;
    logic [ADDR_WIDTH-1:0] wr_addr_next;
    logic [7:0]            wr_data_next, tx_data_next;
    logic                  raise_error, send_ok;

    // Panel layout: 16 column blocks of 384 bytes, 8 sub-blocks of 48, rows 0..15 stored after 16..31.
    function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [6:0] px, input logic [4:0] py);
        logic [ADDR_WIDTH-1:0] row;
        row = (py < 5'd16) ? ADDR_WIDTH'(py) + ADDR_WIDTH'(32) : ADDR_WIDTH'(py);
        return ADDR_WIDTH'(px[3:0]) * ADDR_WIDTH'(384) + ADDR_WIDTH'(px[6:4]) * ADDR_WIDTH'(48) + row;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            idle_count <= '0;
            wr_enable  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            tx_data    <= '0;
            tx_strobe  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            x          <= x_next;
            y          <= y_next;
            idle_count <= idle_count_next;
            wr_enable  <= wr_enable_next;
            wr_addr    <= wr_addr_next;
            wr_data    <= wr_data_next;
            tx_data    <= tx_data_next;
            tx_strobe  <= tx_strobe_next;
            frame_done <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        x_next          = x;
        y_next          = y;
        wr_enable_next  = 1'b0;
        wr_addr_next    = wr_addr;
        wr_data_next    = wr_data;
        tx_data_next    = tx_data;
        tx_strobe_next  = 1'b0;
        frame_done_next = 1'b0;
        raise_error     = 1'b0;
        send_ok         = 1'b0;

        // An arriving byte takes priority over a timeout expiring in the same cycle.
        if (rx_strobe) begin
            unique case (state)
                IDLE: if (rx_data == SYNC_BYTE) state_next = CMD;
                CMD: begin
                    if (rx_data == 8'h01) begin
                        state_next = FRAME;
                        x_next     = '0;
                        y_next     = '0;
                    end else if (rx_data == 8'h02) begin
                        state_next = PX_X;
                    end else begin
                        raise_error = 1'b1;
                    end
                end
                FRAME: begin
                    wr_enable_next = 1'b1;
                    wr_addr_next   = map_addr(x[6:0], y[4:0]);
                    wr_data_next   = rx_data;
                    if (y == 8'd31) begin
                        y_next = '0;
                        if (x == 8'd127) begin
                            send_ok         = 1'b1;
                            frame_done_next = 1'b1;
                        end else begin
                            x_next = x + 8'd1;
                        end
                    end else begin
                        y_next = y + 8'd1;
                    end
                end
                PX_X: begin
                    x_next     = rx_data;
                    state_next = PX_Y;
                end
                PX_Y: begin
                    y_next     = rx_data;
                    state_next = PX_V;
                end
                PX_V: begin
                    if (x > 8'd127 || y > 8'd31) begin
                        raise_error = 1'b1;
                    end else begin
                        wr_enable_next = 1'b1;
                        wr_addr_next   = map_addr(x[6:0], y[4:0]);
                        wr_data_next   = rx_data;
                        send_ok        = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE && idle_count == TIMEOUT) begin
            raise_error = 1'b1;
        end

        if (send_ok) begin
            tx_data_next   = ACK_OK;
            tx_strobe_next = 1'b1;
            state_next     = IDLE;
        end
        if (raise_error) begin
            tx_data_next   = ACK_ERR;
            tx_strobe_next = 1'b1;
            state_next     = IDLE;
        end

        idle_count_next = (state_next == IDLE || rx_strobe) ? '0 : idle_count + 20'd1;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fb_writer.sv
// Directed + randomized bench for fb_writer: captured RAM writes and acks are compared
// against a packet-level model of the frame-buffer mapping and acknowledge rules.
module tb_fb_writer;

    localparam int AW = 13;
    localparam int TMO = 48000;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_strobe;
    logic          wr_enable;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    tx_data;
    logic          tx_strobe;
    logic          frame_done;
    logic          busy;

    fb_writer dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_data(tx_data), .tx_strobe(tx_strobe), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [20:0] wr_q[$];
    logic [20:0] exp_wr[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_tx[$];
    int fd_count = 0;
    int fd_bad = 0;

    always @(negedge clk) begin
        if (wr_enable) wr_q.push_back({wr_addr, wr_data});
        if (tx_strobe) tx_q.push_back(tx_data);
        if (frame_done) begin
            fd_count++;
            if (!(tx_strobe && wr_enable && tx_data == 8'h4B)) fd_bad++;
        end
    end

    function automatic int ref_map(input int x, input int y);
        return (x % 16) * 384 + (x / 16) * 48 + ((y < 16) ? y + 32 : y);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the byte is sampled at the next rising edge.
    task automatic send(input logic [7:0] b);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wr_enable"}, 32'(wr_enable), 0);
        check({tag, " wr_addr"}, 32'(wr_addr), 0);
        check({tag, " wr_data"}, 32'(wr_data), 0);
        check({tag, " tx_data"}, 32'(tx_data), 0);
        check({tag, " tx_strobe"}, 32'(tx_strobe), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " busy"}, 32'(busy), 0);
    endtask

    task automatic check_traffic(input string tag);
        check({tag, " write count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            check({tag, " write"}, 32'(wr_q[i]), 32'(exp_wr[i]));
        check({tag, " ack count"}, 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
            check({tag, " ack"}, 32'(tx_q[i]), 32'(exp_tx[i]));
        wr_q.delete(); exp_wr.delete(); tx_q.delete(); exp_tx.delete();
    endtask

    // Model: in-range pixel writes one byte and acks 'K'; out-of-range acks 'E' with no write.
    task automatic pixel(input string tag, input int x, input int y, input logic [7:0] v);
        send(8'hA5); send(8'h02); send(8'(x)); send(8'(y)); send(v);
        if (x > 127 || y > 31) begin
            exp_tx.push_back(8'h45);
            check({tag, " no write"}, 32'(wr_enable), 0);
        end else begin
            exp_wr.push_back({13'(ref_map(x, y)), v});
            exp_tx.push_back(8'h4B);
            check({tag, " wr_enable at N+1"}, 32'(wr_enable), 1);
        end
        check({tag, " tx_strobe at N+1"}, 32'(tx_strobe), 1);
        check({tag, " busy low"}, 32'(busy), 0);
        idle(1);
        check({tag, " wr_enable one cycle"}, 32'(wr_enable), 0);
        check_traffic(tag);
    endtask

    initial begin
        logic [7:0] b;
        bit seen[0:6143];
        int dups, over, n;

        reset = 1'b1;
        rx_strobe = 1'b0;
        rx_data = 8'h00;
        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        pixel("px 5,3", 5, 3, 8'h7F);
        check("px 5,3 addr", 32'(wr_addr), 1955);
        pixel("px 19,20", 19, 20, 8'hFF);
        check("px 19,20 addr", 32'(wr_addr), 1220);

        send(8'hA5); send(8'h07);
        check("bad cmd tx_strobe", 32'(tx_strobe), 1);
        check("bad cmd tx_data", 32'(tx_data), 32'h45);
        check("bad cmd no write", 32'(wr_enable), 0);
        check("bad cmd busy", 32'(busy), 0);
        exp_tx.push_back(8'h45);
        idle(1);
        check_traffic("bad cmd");
        pixel("px 0,0 after err", 0, 0, 8'h11);
        check("px 0,0 addr", 32'(wr_addr), 32);
        pixel("px x=128", 128, 0, 8'h55);

        // Random pixel packets preceded by junk bytes that IDLE must drop.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send(b);
                idle($urandom_range(0, 3));
            end
            pixel("rand px", $urandom_range(0, 140), $urandom_range(0, 40), 8'($urandom));
        end

        // Full frame, back-to-back bytes; 8'hA5 data values must not resync.
        fd_count = 0; fd_bad = 0;
        send(8'hA5); send(8'h01);
        for (int i = 0; i < 4096; i++) begin
            send(8'(i));
            exp_wr.push_back({13'(ref_map(i / 32, i % 32)), 8'(i)});
        end
        exp_tx.push_back(8'h4B);
        check("frame busy low", 32'(busy), 0);
        idle(1);
        check("frame write count", 32'(wr_q.size()), 4096);
        if (wr_q.size() == 4096) begin
            check("frame first addr", 32'(wr_q[0][20:8]), 32);
            check("frame 17th addr", 32'(wr_q[16][20:8]), 16);
            check("frame last addr", 32'(wr_q[4095][20:8]), 6127);
        end
        dups = 0; over = 0;
        foreach (wr_q[i]) begin
            if (int'(wr_q[i][20:8]) > 6143) over++;
            else if (seen[int'(wr_q[i][20:8])]) dups++;
            else seen[int'(wr_q[i][20:8])] = 1'b1;
        end
        check("frame duplicate addrs", 32'(dups), 0);
        check("frame addrs out of range", 32'(over), 0);
        check("frame_done pulses", 32'(fd_count), 1);
        check("frame_done coincident with K", 32'(fd_bad), 0);
        check_traffic("frame");

        // Timeout inside a frame after 10 data bytes.
        send(8'hA5); send(8'h01);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send(b);
            exp_wr.push_back({13'(ref_map(0, i)), b});
        end
        n = 0;
        while (!tx_strobe && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout latency", 32'(n), 32'(TMO + 1));
        check("timeout tx_data", 32'(tx_data), 32'h45);
        check("timeout busy", 32'(busy), 0);
        exp_tx.push_back(8'h45);
        idle(1);
        check_traffic("timeout");

        // Reset in the middle of a frame.
        send(8'hA5); send(8'h01);
        for (int i = 0; i < 100; i++) begin
            send(8'(i + 7));
            exp_wr.push_back({13'(ref_map(i / 32, i % 32)), 8'(i + 7)});
        end
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid-frame reset");
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        check_traffic("pre-reset frame");
        send(8'hA5); send(8'h01);
        for (int i = 0; i < 33; i++) send(8'(i));
        idle(1);
        check("restart write count", 32'(wr_q.size()), 33);
        if (wr_q.size() == 33) begin
            check("restart first addr", 32'(wr_q[0][20:8]), 32);
            check("restart 17th addr", 32'(wr_q[16][20:8]), 16);
            check("restart 33rd addr", 32'(wr_q[32][20:8]), 416);
        end
        check("restart busy", 32'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
